// File: rtl/pwm_oc_pkg.sv
// rtl/pwm_oc_pkg.sv - shared types and constants for the PWM output-stage break controller
// Purpose: FSM state encoding and default break-filter width.
// Contents: pwm_oc_state_t (ST_IDLE, ST_RUN, ST_BRK), FILT_WIDTH_DEF.
package pwm_oc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_BRK  = 2'b10
    } pwm_oc_state_t;

    localparam int FILT_WIDTH_DEF = 4;

endpackage

// File: rtl/pwm_oc_brk_filter.sv
// rtl/pwm_oc_brk_filter.sv - break input synchroniser, polarity select and consecutive-sample filter
// Purpose: turns the raw asynchronous break pin into a registered, filtered break detect.
// Ports:
//   clk_psc_i   prescaled clock
//   rst_i       synchronous reset, active-high
//   brk_i       raw asynchronous break input
//   brk_pol_i   1 = active-high break, 0 = active-low break
//   brk_filt_i  extra consecutive active samples required
//   brk_det_o   registered break detect
// Macro PWM_OC_BRK_FILTER_EN: when defined the sample counter is built; otherwise
// brk_det_o is the registered active sample and brk_filt_i is ignored.
module pwm_oc_brk_filter
    import pwm_oc_pkg::*;
#(
    parameter int FILT_WIDTH = FILT_WIDTH_DEF
) (
    input  logic                  clk_psc_i,
    input  logic                  rst_i,
    input  logic                  brk_i,
    input  logic                  brk_pol_i,
    input  logic [FILT_WIDTH-1:0] brk_filt_i,
    output logic                  brk_det_o
);

    logic sync1;
    logic sync2;
    logic active;

    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= brk_i;
            sync2 <= sync1;
        end
    end

    assign active = sync2 ^ ~brk_pol_i;

`ifdef PWM_OC_BRK_FILTER_EN
    logic [FILT_WIDTH-1:0] cnt;

    // cnt holds the number of consecutive active samples seen before this one,
    // so this sample completes the run when cnt has reached brk_filt_i.
    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            cnt       <= '0;
            brk_det_o <= 1'b0;
        end else if (active) begin
            if (cnt != {FILT_WIDTH{1'b1}}) begin
                cnt <= cnt + 1'b1;
            end
            brk_det_o <= (cnt >= brk_filt_i);
        end else begin
            cnt       <= '0;
            brk_det_o <= 1'b0;
        end
    end
`else
    logic unused_filt;
    assign unused_filt = ^brk_filt_i;

    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            brk_det_o <= 1'b0;
        end else begin
            brk_det_o <= active;
        end
    end
`endif

endmodule

// File: rtl/pwm_oc_break_ctrl.sv
// rtl/pwm_oc_break_ctrl.sv - main output enable and break controller for one complementary PWM channel
// Purpose: sequences the pad stage through IDLE/RUN/BRK, keeps a sticky break flag and
// muxes PWM data, idle levels or tri-state onto the pads.
// Ports:
//   clk_psc_i, rst_i                 clock, synchronous active-high reset
//   update_event_i, aoe_i            update pulse and automatic re-enable on it
//   brk_i, brk_en_i, brk_pol_i       raw break pin, enable, polarity
//   brk_filt_i                       extra consecutive break samples required
//   moe_set_i, moe_clr_i             software MOE set / clear pulses
//   ossi_i, ois_high_i, ois_low_i    off-state select and idle levels
//   brk_flag_clr_i                   clears brk_flag_o
//   pwm_high_i, pwm_low_i            drive from the deadtime stage
//   pwm_high_o, pwm_low_o            pad data
//   oe_high_o, oe_low_o              pad output enables
//   moe_o, brk_flag_o                main output enable, sticky break flag
// Macro PWM_OC_BRK_FILTER_EN: enables the break filter counter in pwm_oc_brk_filter.
module pwm_oc_break_ctrl
    import pwm_oc_pkg::*;
#(
    parameter int FILT_WIDTH = FILT_WIDTH_DEF
) (
    input  logic                  clk_psc_i,
    input  logic                  rst_i,
    input  logic                  update_event_i,
    input  logic                  brk_i,
    input  logic                  brk_en_i,
    input  logic                  brk_pol_i,
    input  logic [FILT_WIDTH-1:0] brk_filt_i,
    input  logic                  aoe_i,
    input  logic                  moe_set_i,
    input  logic                  moe_clr_i,
    input  logic                  ossi_i,
    input  logic                  ois_high_i,
    input  logic                  ois_low_i,
    input  logic                  brk_flag_clr_i,
    input  logic                  pwm_high_i,
    input  logic                  pwm_low_i,
    output logic                  pwm_high_o,
    output logic                  pwm_low_o,
    output logic                  oe_high_o,
    output logic                  oe_low_o,
    output logic                  moe_o,
    output logic                  brk_flag_o
);

    pwm_oc_state_t state;
    pwm_oc_state_t state_next;
    logic          brk_det;
    logic          brk_act;

    pwm_oc_brk_filter #(
        .FILT_WIDTH (FILT_WIDTH)
    ) u_brk_filter (
        .clk_psc_i  (clk_psc_i),
        .rst_i      (rst_i),
        .brk_i      (brk_i),
        .brk_pol_i  (brk_pol_i),
        .brk_filt_i (brk_filt_i),
        .brk_det_o  (brk_det)
    );

    assign brk_act = brk_det & brk_en_i;

    always_ff @(posedge clk_psc_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            brk_flag_o <= 1'b0;
        end else begin
            state <= state_next;
            if (brk_act) begin
                brk_flag_o <= 1'b1;
            end else if (brk_flag_clr_i) begin
                brk_flag_o <= 1'b0;
            end
        end
    end

    // BRK only exits to IDLE, so re-enabling always takes a fresh set or update.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if ((moe_set_i | (aoe_i & update_event_i)) & ~brk_act & ~moe_clr_i) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (brk_act) begin
                    state_next = ST_BRK;
                end else if (moe_clr_i) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BRK: begin
                if (~brk_act) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign moe_o = (state == ST_RUN);

    // Idle low level is masked by the high level so both switches never conduct.
    always_comb begin
        pwm_high_o = 1'b0;
        pwm_low_o  = 1'b0;
        oe_high_o  = 1'b0;
        oe_low_o   = 1'b0;
        if (!rst_i) begin
            if (moe_o) begin
                pwm_high_o = pwm_high_i;
                pwm_low_o  = pwm_low_i;
                oe_high_o  = 1'b1;
                oe_low_o   = 1'b1;
            end else if (ossi_i) begin
                pwm_high_o = ois_high_i;
                pwm_low_o  = ois_low_i & ~ois_high_i;
                oe_high_o  = 1'b1;
                oe_low_o   = 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_oc_break_ctrl.md
# pwm_oc_break_ctrl

Main-output-enable (MOE) and break controller for one complementary PWM channel. It sits between `pwm_oc_deadtime` and the pads, and sequences the output stage through run, break and idle states. It synchronises and filters an external break input, forces programmed idle levels or tri-state on fault, and re-arms outputs either by software or automatically on an update event.

## Interface
Parameters:
- FILT_WIDTH, 4, width of the break-filter sample count

Ports (the clock is single; the reset is synchronous and active-high):
- clk_psc_i  in  1  prescaled clock
- rst_i  in  1  synchronous reset, active-high
- update_event_i  in  1  update-event pulse, one cycle
- brk_i  in  1  raw asynchronous break input
- brk_en_i  in  1  break function enable
- brk_pol_i  in  1  break polarity: 1 = active-high, 0 = active-low
- brk_filt_i  in  FILT_WIDTH  number of extra consecutive active samples required
- aoe_i  in  1  automatic output enable on update event
- moe_set_i  in  1  software MOE set pulse
- moe_clr_i  in  1  software MOE clear pulse
- ossi_i  in  1  off-state select when idle: 1 = drive idle levels, 0 = release (oe=0)
- ois_high_i  in  1  idle level for the high-side output
- ois_low_i  in  1  idle level for the low-side output
- brk_flag_clr_i  in  1  clears the sticky break flag
- pwm_high_i  in  1  high-side drive from the deadtime stage
- pwm_low_i  in  1  low-side drive from the deadtime stage
- pwm_high_o  out  1  high-side pad data
- pwm_low_o  out  1  low-side pad data
- oe_high_o  out  1  high-side pad output enable
- oe_low_o  out  1  low-side pad output enable
- moe_o  out  1  registered main output enable
- brk_flag_o  out  1  sticky break-occurred flag

## Operation
Break detection path:
- brk_i passes through a two-flop synchroniser.
- The synchronised value is XORed with ~brk_pol_i to give the active sample.
- The filter counter counts consecutive active samples and resets to 0 on any inactive sample.
- Registered brk_det asserts once brk_filt_i+1 consecutive active samples are seen, and deasserts on the first inactive sample.
- The counter saturates; it never wraps.

FSM states: IDLE (moe_o=0), RUN (moe_o=1), BRK (moe_o=0).
- IDLE → RUN: (moe_set_i | (aoe_i & update_event_i)) & ~(brk_det & brk_en_i) & ~moe_clr_i.
- RUN → BRK: brk_det & brk_en_i. This has the highest priority.
- RUN → IDLE: moe_clr_i, with no break present.
- BRK → IDLE: ~brk_det | ~brk_en_i. moe_set_i and update events are ignored while in BRK.
- BRK is left only via IDLE. Re-enable therefore always needs a fresh set or update event.

brk_flag_o:
- Set on any cycle where brk_det & brk_en_i, in any state.
- Cleared by brk_flag_clr_i. Set wins when both occur in the same cycle.

Output mapping (combinational, from moe_o and the inputs):
- moe_o=1: pwm_*_o = pwm_*_i and oe_*_o = 1.
- moe_o=0, ossi_i=1: pwm_high_o = ois_high_i and pwm_low_o = ois_low_i & ~ois_high_i (never both high); oe_*_o = 1.
- moe_o=0, ossi_i=0: pwm_*_o = 0 and oe_*_o = 0.
- While rst_i is high, all four pad outputs are forced to 0 combinationally.

## Timing
- Reset: state=IDLE, moe_o=0, brk_flag_o=0, filter counter=0, synchroniser=0, brk_det=0.
- Break latency, with brk_i active before edge k:
  - brk_det rises at edge k+2+brk_filt_i.
  - moe_o falls at edge k+3+brk_filt_i.
  - Pads switch in the same cycle as moe_o.
- MOE set latency: moe_set_i sampled at edge k gives moe_o=1 after edge k. A cycle with moe_set_i and moe_clr_i together leaves the state in IDLE.
- The PWM data path has zero cycles of latency and is purely combinational.
- brk_filt_i, brk_pol_i and brk_en_i are sampled every cycle; they are not shadowed.
- A change in brk_filt_i mid-count takes effect immediately against the current count.
- Asserting reset mid-break returns to IDLE with the flag cleared. The break is re-detected after the full latency if brk_i is still active.

## Configuration
- PWM_OC_BRK_FILTER_EN defined: the filter counter is present and behaves as described above.
- Undefined: no counter is built. brk_det is the registered active sample, brk_filt_i is ignored, and break latency is fixed at 3 cycles.

## Structure
- Shared package pwm_oc_pkg holds:
  - the FSM state typedef, 2 bits: ST_IDLE=2'b00, ST_RUN=2'b01, ST_BRK=2'b10;
  - the default FILT_WIDTH constant.
- Sub-module pwm_oc_brk_filter contains the synchroniser, polarity XOR and filter counter, and outputs brk_det.
- The FSM, sticky flag and output mux live in the top level.

## Test plan
- Reset, then moe_set_i pulse with brk_i inactive → moe_o=1 one edge later; pads follow pwm_*_i with oe=1.
- RUN, brk_pol_i=1, brk_filt_i=3, brk_i high for 4 cycles → moe_o=0 at edge k+6; brk_flag_o=1; pads show ois levels when ossi_i=1.
- brk_filt_i=3 with brk_i high for only 3 cycles → no break; moe_o stays 1 and brk_flag_o=0.
- In BRK, release brk_i with aoe_i=1 and update_event_i → IDLE first, then RUN on the next update event; brk_flag_o holds until brk_flag_clr_i.
- IDLE with ossi_i=0 → pwm_*_o=0 and oe_*_o=0. With ossi_i=1 and ois_high_i=ois_low_i=1 → pwm_high_o=1 and pwm_low_o=0.
- brk_en_i=0 with brk_i active → no state change and no flag. Simultaneous moe_set_i/moe_clr_i in IDLE → stays in IDLE.
